// File: rtl/seq_processor.sv
// Multi-cycle fetch/execute core with loadable instruction memory, parametrised
// register file and data width, run/halt control, flag-conditional branches and debug read port.
module seq_processor #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 16,
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [31:0]        prog_data,
  input  logic [3:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [IMEM_AW-1:0] pc,
  output logic               busy,
  output logic               halted,
  output logic               retire,
  output logic               flag_z,
  output logic               flag_c
);

  localparam int RIDX_W     = $clog2(NREG);
  localparam int IMEM_DEPTH = 1 << IMEM_AW;

  localparam logic [3:0] OP_LOAD   = 4'd0;
  localparam logic [3:0] OP_MOV    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_ADD    = 4'd3;
  localparam logic [3:0] OP_LDPC   = 4'd4;
  localparam logic [3:0] OP_BRANCH = 4'd5;
  localparam logic [3:0] OP_HALT   = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] reg_view [16];

  // Control protocol: start and prog_we are single-cycle strobes that are
  // accepted only while the core is idle (busy=0); any strobe seen while busy
  // is dropped with no side effect. Completion is signalled by halted=1.
  logic fetch_en;
  logic exec_en;
  logic start_acc;
  logic imem_we;

  logic [3:0]         op;
  logic [3:0]         cond;
  logic [3:0]         ra;
  logic [3:0]         rb;
  logic [15:0]        imm;
  logic [DATA_W-1:0]  imm_d;
  logic [DATA_W-1:0]  ra_val;
  logic [DATA_W-1:0]  rb_val;
  logic [DATA_W-1:0]  xor_res;
  logic [DATA_W:0]    sum;
  logic [IMEM_AW-1:0] pc_inc;
  logic [IMEM_AW-1:0] br_target;

  logic              wr_en;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_data;
  logic              z_new;
  logic              c_new;
  logic              br_taken;
  logic              is_halt;

  // Out-of-range register indices read as zero through a fixed 16-entry view.
  for (genvar g = 0; g < 16; g++) begin : g_view
    if (g < NREG) begin : g_live
      assign reg_view[g] = regs[g];
    end else begin : g_none
      assign reg_view[g] = '0;
    end
  end

  assign dbg_data = reg_view[dbg_sel];

  assign op        = ir[31:28];
  assign cond      = ir[27:24];
  assign ra        = ir[23:20];
  assign rb        = ir[19:16];
  assign imm       = ir[15:0];
  assign imm_d     = DATA_W'(imm);
  assign br_target = IMEM_AW'(imm);
  assign ra_val    = reg_view[ra];
  assign rb_val    = reg_view[rb];
  assign xor_res   = ra_val ^ rb_val;
  assign sum       = {1'b0, ra_val} + {1'b0, rb_val};
  assign pc_inc    = pc + IMEM_AW'(1);
  assign wr_ok     = wr_en && (int'(ra) < NREG);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = is_halt ? S_IDLE : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state != S_IDLE);
    fetch_en  = (state == S_FETCH);
    exec_en   = (state == S_EXEC);
    start_acc = (state == S_IDLE) && start;
    imem_we   = (state == S_IDLE) && prog_we;
  end

  // Instruction decode; flags default to their current values so that
  // non-ALU instructions leave them untouched.
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = '0;
    z_new    = flag_z;
    c_new    = flag_c;
    br_taken = 1'b0;
    is_halt  = 1'b0;
    case (op)
      OP_LOAD: begin
        wr_en   = 1'b1;
        wr_data = imm_d;
      end
      OP_MOV: begin
        wr_en   = 1'b1;
        wr_data = rb_val;
      end
      OP_XOR: begin
        wr_en   = 1'b1;
        wr_data = xor_res;
        z_new   = (xor_res == '0);
        c_new   = 1'b0;
      end
      OP_ADD: begin
        wr_en   = 1'b1;
        wr_data = sum[DATA_W-1:0];
        z_new   = (sum[DATA_W-1:0] == '0);
        c_new   = sum[DATA_W];
      end
      OP_LDPC: begin
        wr_en   = 1'b1;
        wr_data = DATA_W'(pc_inc);
      end
      OP_BRANCH: begin
        case (cond)
          4'd0:    br_taken = 1'b1;
          4'd1:    br_taken = flag_z;
          4'd2:    br_taken = flag_c;
          default: br_taken = 1'b0;
        endcase
      end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Instruction memory has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[prog_addr] <= prog_data;
    end
  end

  // Datapath: a reset during EXEC wins over the commit, abandoning the instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      halted <= 1'b0;
      retire <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      retire <= exec_en;
      if (start_acc) begin
        halted <= 1'b0;
      end
      if (fetch_en) begin
        ir <= imem[pc];
      end
      if (exec_en) begin
        pc     <= br_taken ? br_target : pc_inc;
        flag_z <= z_new;
        flag_c <= c_new;
        if (is_halt) begin
          halted <= 1'b1;
        end
        if (wr_ok) begin
          regs[ra[RIDX_W-1:0]] <= wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_processor.sv
// Bench for seq_processor (DATA_W=16, NREG=4, IMEM_AW=8): directed programs
// plus random forward-branching programs checked against an ISA-level model.
module tb_seq_processor;

  localparam int DATA_W  = 16;
  localparam int NREG    = 4;
  localparam int IMEM_AW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               prog_we;
  logic [IMEM_AW-1:0] prog_addr;
  logic [31:0]        prog_data;
  logic [3:0]         dbg_sel;
  logic [DATA_W-1:0]  dbg_data;
  logic [IMEM_AW-1:0] pc;
  logic               busy;
  logic               halted;
  logic               retire;
  logic               flag_z;
  logic               flag_c;

  int vectors = 0;
  int errors  = 0;
  logic [DATA_W-1:0] exp_q[$];

  // ISA-level reference model state
  int unsigned m_mem [256];
  int unsigned m_reg [16];
  bit          m_z;
  bit          m_c;
  bit          m_halted;
  int unsigned m_pc;
  int          op_tab [9] = '{0, 1, 2, 3, 4, 5, 3, 2, 11};

  seq_processor #(.DATA_W(DATA_W), .NREG(NREG), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .pc(pc), .busy(busy), .halted(halted),
    .retire(retire), .flag_z(flag_z), .flag_c(flag_c)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input int op, input int cond, input int ra,
                                      input int rb, input int imm);
    return {4'(op), 4'(cond), 4'(ra), 4'(rb), 16'(imm)};
  endfunction

  function automatic int unsigned m_rd(input int unsigned idx);
    return (idx < NREG) ? m_reg[idx] : 0;
  endfunction

  function automatic void m_wr(input int unsigned idx, input int unsigned v);
    if (idx < NREG) m_reg[idx] = v & 32'hFFFF;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    m_z = 0; m_c = 0; m_halted = 0; m_pc = 0;
  endfunction

  // Executes from m_pc until HALT; returns number of instructions retired.
  function automatic int m_run();
    int n;
    int unsigned w, op, cond, ra, rb, imm, nxt, s, x;
    bit t;
    n = 0;
    m_halted = 0;
    while (n < 5000) begin
      w = m_mem[m_pc];
      op = w >> 28; cond = (w >> 24) & 15; ra = (w >> 20) & 15; rb = (w >> 16) & 15;
      imm = w & 32'hFFFF;
      nxt = (m_pc + 1) % 256;
      n++;
      case (op)
        0: m_wr(ra, imm);
        1: m_wr(ra, m_rd(rb));
        2: begin x = m_rd(ra) ^ m_rd(rb); m_wr(ra, x); m_z = (x == 0); m_c = 0; end
        3: begin
          s = m_rd(ra) + m_rd(rb);
          m_wr(ra, s);
          m_c = (s > 32'hFFFF);
          m_z = ((s & 32'hFFFF) == 0);
        end
        4: m_wr(ra, nxt);
        5: begin
          t = (cond == 0) || (cond == 1 && m_z) || (cond == 2 && m_c);
          if (t) nxt = imm % 256;
        end
        6: begin m_pc = nxt; m_halted = 1; return n; end
        default: ;
      endcase
      m_pc = nxt;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; prog_we = 0;
    @(negedge clk);
    rst = 0;
    m_reset();
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    @(negedge clk);
    prog_we = 1; prog_addr = 8'(addr); prog_data = w;
    @(negedge clk);
    prog_we = 0;
    m_mem[addr] = w;
  endtask

  task automatic read_reg(input int idx, output logic [DATA_W-1:0] v);
    @(negedge clk);
    dbg_sel = 4'(idx);
    #1 v = dbg_data;
  endtask

  // Pulses start (optionally with a same-cycle write), optionally fires a
  // write+start pair while busy at cycle g_cycle, then waits for halt.
  task automatic run_prog(input bit co_we, input int co_addr, input logic [31:0] co_data,
                          input int g_cycle, input int g_addr, input logic [31:0] g_data,
                          output int retires, output int busys);
    bit done;
    int cyc;
    @(negedge clk);
    start = 1;
    if (co_we) begin
      prog_we = 1; prog_addr = 8'(co_addr); prog_data = co_data;
      m_mem[co_addr] = co_data;
    end
    retires = 0; busys = 0; done = 0; cyc = 0;
    @(negedge clk);
    start = 0; prog_we = 0;
    while (!done && cyc < 4000) begin
      if (busy) busys++;
      if (retire) retires++;
      if (halted && !busy) begin
        done = 1;
      end else begin
        cyc++;
        if (cyc == g_cycle) begin
          start = 1; prog_we = 1; prog_addr = 8'(g_addr); prog_data = g_data;
        end else begin
          start = 0; prog_we = 0;
        end
        @(negedge clk);
      end
    end
    start = 0; prog_we = 0;
    check("run_completes", 32'(done), 32'd1);
  endtask

  // Scoreboard: expected register file queued from the model, then drained.
  task automatic check_state(input string tag);
    logic [DATA_W-1:0] v;
    int hi;
    for (int i = 0; i < NREG; i++) exp_q.push_back(DATA_W'(m_rd(i)));
    for (int i = 0; i < NREG; i++) begin
      read_reg(i, v);
      check($sformatf("%s_r%0d", tag, i), 32'(v), 32'(exp_q.pop_front()));
    end
    hi = $urandom_range(NREG, 15);
    read_reg(hi, v);
    check($sformatf("%s_dbg%0d", tag, hi), 32'(v), 32'd0);
    check({tag, "_z"}, 32'(flag_z), 32'(m_z));
    check({tag, "_c"}, 32'(flag_c), 32'(m_c));
    check({tag, "_pc"}, 32'(pc), m_pc);
    check({tag, "_halted"}, 32'(halted), 32'(m_halted));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic gen_prog(input int n);
    int op, cond, ra, rb, imm;
    for (int i = 0; i < n; i++) begin
      op   = op_tab[$urandom_range(0, 8)];
      cond = $urandom_range(0, 3);
      ra   = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      rb   = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      imm  = (op == 5) ? $urandom_range(i + 1, n) : $urandom_range(0, 65535);
      load_word(i, ins(op, cond, ra, rb, imm));
    end
    load_word(n, ins(6, 0, 0, 0, $urandom_range(0, 65535)));
  endtask

  initial begin
    int rets, busys, n, exp_n;
    logic [DATA_W-1:0] v;
    rst = 1; start = 0; prog_we = 0; prog_addr = '0; prog_data = '0; dbg_sel = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("reset_retire", 32'(retire), 32'd0);
    check_state("reset");

    // Basic program
    load_word(0, ins(0, 0, 0, 0, 5));
    load_word(1, ins(0, 0, 1, 0, 10));
    load_word(2, ins(3, 0, 0, 1, 0));
    load_word(3, ins(1, 0, 2, 0, 0));
    load_word(4, ins(0, 0, 3, 0, 16'hAA));
    load_word(5, ins(2, 0, 2, 3, 0));
    load_word(6, ins(6, 0, 0, 0, 0));
    run_prog(0, 0, 0, 0, 0, 0, rets, busys);
    exp_n = m_run();
    check("t1_retires", 32'(rets), 32'd7);
    check("t1_busy_cycles", 32'(busys), 32'd14);
    check("t1_model_retires", 32'(rets), 32'(exp_n));
    read_reg(0, v); check("t1_r0", 32'(v), 32'd15);
    read_reg(2, v); check("t1_r2", 32'(v), 32'hA5);
    check("t1_pc", 32'(pc), 32'd7);
    check_state("t1");

    // ADD carry then carry-conditional branch
    do_reset();
    load_word(0, ins(0, 0, 0, 0, 16'hFFFF));
    load_word(1, ins(0, 0, 1, 0, 1));
    load_word(2, ins(3, 0, 0, 1, 0));
    load_word(3, ins(5, 2, 0, 0, 16'h20));
    load_word(4, ins(0, 0, 2, 0, 1));
    load_word(5, ins(6, 0, 0, 0, 0));
    load_word(16'h20, ins(6, 0, 0, 0, 0));
    run_prog(0, 0, 0, 0, 0, 0, rets, busys);
    exp_n = m_run();
    read_reg(0, v); check("t2_r0", 32'(v), 32'd0);
    read_reg(2, v); check("t2_r2_skipped", 32'(v), 32'd0);
    check("t2_z", 32'(flag_z), 32'd1);
    check("t2_c", 32'(flag_c), 32'd1);
    check("t2_pc", 32'(pc), 32'h21);
    check_state("t2");

    // Counted loop, exit on Z, then LDPC at address 9
    do_reset();
    load_word(0, ins(0, 0, 0, 0, 3));
    load_word(1, ins(0, 0, 1, 0, 16'hFFFF));
    load_word(2, ins(3, 0, 0, 1, 0));
    load_word(3, ins(5, 1, 0, 0, 5));
    load_word(4, ins(5, 0, 0, 0, 2));
    for (int a = 5; a < 9; a++) load_word(a, ins(7, 0, 0, 0, 0));
    load_word(9, ins(4, 0, 2, 0, 0));
    load_word(10, ins(6, 0, 0, 0, 0));
    run_prog(0, 0, 0, 0, 0, 0, rets, busys);
    exp_n = m_run();
    check("t3_retires", 32'(rets), 32'd16);
    read_reg(0, v); check("t3_r0", 32'(v), 32'd0);
    read_reg(2, v); check("t3_ldpc", 32'(v), 32'd10);
    check("t3_pc", 32'(pc), 32'd11);
    check_state("t3");

    // Out-of-range register indices
    do_reset();
    load_word(0, ins(0, 0, 0, 0, 16'h12));
    load_word(1, ins(0, 0, 1, 0, 16'h34));
    load_word(2, ins(0, 0, 7, 0, 16'h55));
    load_word(3, ins(1, 0, 0, 7, 0));
    load_word(4, ins(6, 0, 0, 0, 0));
    run_prog(0, 0, 0, 0, 0, 0, rets, busys);
    exp_n = m_run();
    read_reg(0, v); check("t4_r0", 32'(v), 32'd0);
    read_reg(1, v); check("t4_r1", 32'(v), 32'h34);
    read_reg(7, v); check("t4_dbg7", 32'(v), 32'd0);
    check_state("t4");

    // Guards while busy, HALT at top of memory, restart with same-cycle write
    do_reset();
    load_word(0, ins(5, 0, 0, 0, 16'hF0));
    load_word(1, ins(6, 0, 0, 0, 0));
    load_word(16'hF0, ins(7, 0, 0, 0, 0));
    load_word(16'hF1, ins(7, 0, 0, 0, 0));
    load_word(16'hF2, ins(0, 0, 2, 0, 16'h11));
    load_word(16'hF3, ins(5, 0, 0, 0, 16'hFE));
    load_word(16'hFE, ins(0, 0, 3, 0, 16'h77));
    load_word(16'hFF, ins(6, 0, 0, 0, 0));
    run_prog(0, 0, 0, 3, 16'hF2, ins(0, 0, 2, 0, 16'h99), rets, busys);
    exp_n = m_run();
    check("t5_retires", 32'(rets), 32'd7);
    check("t5_busy_cycles", 32'(busys), 32'd14);
    read_reg(2, v); check("t5_guarded_word", 32'(v), 32'h11);
    check("t5_pc_wrap", 32'(pc), 32'd0);
    check_state("t5a");
    run_prog(1, 0, ins(0, 0, 3, 0, 16'h42), 0, 0, 0, rets, busys);
    exp_n = m_run();
    check("t5_restart_retires", 32'(rets), 32'd2);
    read_reg(3, v); check("t5_restart_r3", 32'(v), 32'h42);
    check("t5_restart_pc", 32'(pc), 32'd2);
    check_state("t5b");

    // Reset during EXEC of a LOAD
    do_reset();
    load_word(0, ins(0, 0, 1, 0, 16'h33));
    load_word(1, ins(6, 0, 0, 0, 0));
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    m_reset();
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_halted", 32'(halted), 32'd0);
    check("t6_pc", 32'(pc), 32'd0);
    read_reg(1, v); check("t6_r1", 32'(v), 32'd0);
    run_prog(0, 0, 0, 0, 0, 0, rets, busys);
    exp_n = m_run();
    read_reg(1, v); check("t6_imem_kept", 32'(v), 32'h33);
    check_state("t6");

    // Random forward-branching programs
    for (int k = 0; k < 12; k++) begin
      do_reset();
      n = $urandom_range(4, 24);
      gen_prog(n);
      run_prog(0, 0, 0, 0, 0, 0, rets, busys);
      exp_n = m_run();
      check($sformatf("rnd%0d_retires", k), 32'(rets), 32'(exp_n));
      check($sformatf("rnd%0d_busy", k), 32'(busys), 32'(2 * exp_n));
      check_state($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
